// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared types and sizing helpers for the sequential adder
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } add_seq_state_t;

  // Number of chunk-wide slices an operand is split into.
  function automatic int num_chunks(input int add_width, input int chunk_width);
    return add_width / chunk_width;
  endfunction

  // Operand width must split into whole chunks.
  function automatic bit widths_ok(input int add_width, input int chunk_width);
    return (chunk_width > 0) && (add_width >= chunk_width) && ((add_width % chunk_width) == 0);
  endfunction

endpackage

// File: rtl/add_seq_adder_if.sv
// rtl/add_seq_adder_if.sv - operand/result handshake bus of the sequential adder
interface add_seq_adder_if #(
  parameter int add_width = 4
);
  logic [add_width-1:0] a;
  logic [add_width-1:0] b;
  logic                 cin;
  logic                 in_valid;
  logic                 in_ready;
  logic [add_width-1:0] sum;
  logic                 cout;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output a, b, cin, in_valid, out_ready,
    input  in_ready, sum, cout, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid, out_ready,
    output in_ready, sum, cout, out_valid
  );
endinterface

// File: rtl/add_seq_adder_chunk_cell.sv
// rtl/add_seq_adder_chunk_cell.sv - combinational chunk-wide adder with carry in/out
module add_chunk_cell #(
  parameter int chunk_width = 1
) (
  input  logic [chunk_width-1:0] a,
  input  logic [chunk_width-1:0] b,
  input  logic                   cin,
  output logic [chunk_width-1:0] sum,
  output logic                   cout
);
  // One extra bit holds the carry out of the chunk.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{chunk_width{1'b0}}, cin};
endmodule

// File: rtl/add_seq_adder.sv
// rtl/add_seq_adder.sv - multi-cycle handshaked adder, chunk_width bits per clock
module add_seq_adder
  import add_seq_pkg::*;
#(
  parameter int add_width   = 4,
  parameter int chunk_width = 1,
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  add_seq_adder_if.slave         bus,
  output logic [count_width-1:0] op_count
);

  localparam int n_chunks  = num_chunks(add_width, chunk_width);
  localparam int idx_width = (n_chunks > 1) ? $clog2(n_chunks) : 1;
  localparam logic [idx_width-1:0] last_idx = idx_width'(n_chunks - 1);

  if (!widths_ok(add_width, chunk_width)) begin : g_bad_widths
    $error("add_seq_adder: add_width must be a non-zero multiple of chunk_width");
  end

  add_seq_state_t         state;
  logic [add_width-1:0]   a_q;
  logic [add_width-1:0]   b_q;
  logic [add_width-1:0]   sum_q;
  logic [add_width-1:0]   sum_next;
  logic                   carry;
  logic [idx_width-1:0]   idx;
  logic [add_width-1:0]   sum_r;
  logic                   cout_r;
  logic                   out_valid_r;
  logic [chunk_width-1:0] cell_sum;
  logic                   cell_cout;

  // A single cell is reused every CALC cycle, fed the slice picked by idx.
  add_chunk_cell #(.chunk_width(chunk_width)) u_cell (
    .a    (a_q[int'(idx) * chunk_width +: chunk_width]),
    .b    (b_q[int'(idx) * chunk_width +: chunk_width]),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // Partial sum with the current chunk merged in, so the last CALC edge can publish it directly.
  always_comb begin
    sum_next = sum_q;
    sum_next[int'(idx) * chunk_width +: chunk_width] = cell_sum;
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.out_valid = out_valid_r;

  // Control FSM: capture operands, walk the chunks, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            carry <= bus.cin;
            sum_q <= '0;
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          sum_q <= sum_next;
          carry <= cell_cout;
          idx   <= idx + 1'b1;
          if (idx == last_idx) begin
            sum_r       <= sum_next;
            cout_r      <= cell_cout;
            out_valid_r <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            op_count    <= op_count + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_adder.sv
// tb/tb_add_seq_adder.sv - randomized self-checking bench for add_seq_adder
module tb_add_seq_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cnt4;
  logic [7:0] cnt8;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         model_cnt4 = 0;
  int         model_cnt8 = 0;

  always #5 clk = ~clk;

  add_seq_adder_if #(.add_width(4)) b4 ();
  add_seq_adder_if #(.add_width(8)) b8 ();

  add_seq_adder #(.add_width(4), .chunk_width(1), .count_width(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(b4), .op_count(cnt4)
  );
  add_seq_adder #(.add_width(8), .chunk_width(2), .count_width(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(b8), .op_count(cnt8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation on the 4-bit/1-bit instance; stall>0 holds out_ready low in HOLD.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input int stall);
    int         k;
    int         lat;
    logic [4:0] exp;
    exp = 5'(a) + 5'(b) + 5'(c);
    b4.a = a; b4.b = b; b4.cin = c; b4.in_valid = 1'b1;
    b4.out_ready = (stall == 0);
    k = 0;
    while (!b4.in_ready && k < 20) begin step(); k++; end
    if (!b4.in_ready) check("accept_timeout4", 0, 1);
    step();
    b4.in_valid = 1'b0; b4.a = ~a; b4.b = ~b; b4.cin = ~c;
    lat = 0;
    while (!b4.out_valid && lat < 40) begin step(); lat++; end
    check("latency4", lat, 4);
    check("sum4", 32'(b4.sum), 32'(exp[3:0]));
    check("cout4", 32'(b4.cout), 32'(exp[4]));
    for (int i = 0; i < stall; i++) begin
      b4.in_valid = i[0]; b4.a = 4'h1;
      step();
      check("hold_valid", 32'(b4.out_valid), 1);
      check("hold_sum", 32'(b4.sum), 32'(exp[3:0]));
      check("hold_ready", 32'(b4.in_ready), 0);
    end
    if (stall > 0) begin
      b4.in_valid = 1'b1;
      b4.out_ready = 1'b1;
    end
    step();
    model_cnt4 = (model_cnt4 + 1) % 16;
    b4.out_ready = 1'b0;
    check("post_xfer_valid", 32'(b4.out_valid), 0);
    check("post_xfer_idle", 32'(b4.in_ready), 1);
    check("op_count4", 32'(cnt4), 32'(model_cnt4));
    b4.in_valid = 1'b0;
  endtask

  // One operation on the 8-bit/2-bit instance, consumer always ready.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int         k;
    int         lat;
    logic [8:0] exp;
    exp = 9'(a) + 9'(b) + 9'(c);
    b8.a = a; b8.b = b; b8.cin = c; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    k = 0;
    while (!b8.in_ready && k < 20) begin step(); k++; end
    if (!b8.in_ready) check("accept_timeout8", 0, 1);
    step();
    b8.in_valid = 1'b0; b8.a = 8'h00; b8.b = 8'h00;
    lat = 0;
    while (!b8.out_valid && lat < 40) begin step(); lat++; end
    check("latency8", lat, 4);
    check("sum8", 32'(b8.sum), 32'(exp[7:0]));
    check("cout8", 32'(b8.cout), 32'(exp[8]));
    step();
    model_cnt8 = (model_cnt8 + 1) % 256;
    check("op_count8", 32'(cnt8), 32'(model_cnt8));
  endtask

  initial begin
    int saw_valid;
    rst = 1'b1;
    b4.a = '0; b4.b = '0; b4.cin = 1'b0; b4.in_valid = 1'b0; b4.out_ready = 1'b0;
    b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.in_valid = 1'b0; b8.out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(b4.in_ready), 0);
    rst = 1'b0;
    step();
    check("rst_out_valid", 32'(b4.out_valid), 0);
    check("rst_sum", 32'(b4.sum), 0);
    check("rst_op_count", 32'(cnt4), 0);
    check("rst_idle_ready", 32'(b4.in_ready), 1);

    op4(4'h3, 4'h5, 1'b0, 0);
    op4(4'hF, 4'h1, 1'b0, 0);
    op4(4'hF, 4'hF, 1'b1, 0);
    op4(4'h6, 4'h7, 1'b0, 10);

    b4.a = 4'h9; b4.b = 4'h9; b4.cin = 1'b0; b4.in_valid = 1'b1;
    step();
    b4.in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("midcalc_rst_ready", 32'(b4.in_ready), 0);
    step();
    rst = 1'b0;
    model_cnt4 = 0;
    #1;
    check("abort_valid", 32'(b4.out_valid), 0);
    check("abort_sum", 32'(b4.sum), 0);
    check("abort_cout", 32'(b4.cout), 0);
    check("abort_count", 32'(cnt4), 0);
    check("abort_ready", 32'(b4.in_ready), 1);
    saw_valid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (b4.out_valid) saw_valid = 1;
    end
    check("abort_no_result", saw_valid, 0);

    for (int i = 0; i < 16; i++) op4(4'($urandom), 4'($urandom), 1'($urandom), 0);
    check("wrap_zero", 32'(cnt4), 0);
    op4(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3));
    check("wrap_one", 32'(cnt4), 1);

    op8(8'hA5, 8'h5B, 1'b1);
    for (int i = 0; i < 8; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
